// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter
//   Shares one single-port display BRAM between the VGA scan-out reader and
//   the host read/write port. Display reads win by default. A wait counter
//   hands the slot to a host that has been refused MAX_WAIT cycles in a row.
//   A clear sequence writes CLR_VAL to every address, one word per cycle.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   disp_req/addr/ack          display read request handshake
//   disp_rvalid/rdata          display read return (rdata = mem_dout)
//   host_req/we/addr/wdata/ack host request handshake (we=1 write, 0 read)
//   host_rvalid/rdata          host read return (rdata = mem_dout)
//   clr_start, clr_busy        start clear (sampled in RUN), clear in progress
//   mem_en/we/addr/din         BRAM port A controls (combinational)
//   mem_dout                   BRAM port A read data
module vga_mem_arbiter #(
  parameter int              AW       = 10,
  parameter int              DW       = 16,
  parameter int              RD_LAT   = 1,
  parameter int              MAX_WAIT = 8,
  parameter logic [DW-1:0]   CLR_VAL  = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_ack,
  output logic          disp_rvalid,
  output logic [DW-1:0] disp_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam int              WCW       = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0]  WAIT_MAX  = WCW'(MAX_WAIT);
  localparam logic [AW-1:0]   LAST_ADDR = '1;

  typedef enum logic {RUN, CLEAR} state_t;

  state_t            state_reg, state_next;
  logic [WCW-1:0]    wait_cnt_reg, wait_cnt_next;
  logic [AW-1:0]     clr_cnt_reg, clr_cnt_next;
  logic [RD_LAT-1:0] disp_pipe_reg, disp_pipe_next;
  logic [RD_LAT-1:0] host_pipe_reg, host_pipe_next;
  logic              host_win;
  logic              disp_rd_acc;
  logic              host_rd_acc;

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    clr_cnt_next  = clr_cnt_reg;
    host_win      = 1'b0;
    disp_ack      = 1'b0;
    host_ack      = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_din       = '0;

    case (state_reg)
      RUN: begin
        // Host takes the slot when display is idle or the host has starved.
        host_win = host_req && (!disp_req || (wait_cnt_reg == WAIT_MAX));
        host_ack = host_win;
        disp_ack = disp_req && !host_win;

        if (host_ack) begin
          mem_en   = 1'b1;
          mem_we   = host_we;
          mem_addr = host_addr;
          mem_din  = host_wdata;
        end else if (disp_ack) begin
          mem_en   = 1'b1;
          mem_addr = disp_addr;
        end

        if (host_req && !host_ack) begin
          if (wait_cnt_reg != WAIT_MAX) begin
            wait_cnt_next = wait_cnt_reg + WCW'(1);
          end
        end else begin
          wait_cnt_next = '0;
        end

        // The current cycle has already arbitrated; clearing starts next cycle.
        if (clr_start) begin
          state_next   = CLEAR;
          clr_cnt_next = '0;
        end
      end

      CLEAR: begin
        // wait_cnt is left untouched so a starving host still wins on return.
        mem_en       = 1'b1;
        mem_we       = 1'b1;
        mem_addr     = clr_cnt_reg;
        mem_din      = CLR_VAL;
        clr_cnt_next = clr_cnt_reg + AW'(1);
        if (clr_cnt_reg == LAST_ADDR) begin
          state_next = RUN;
        end
      end

      default: state_next = RUN;
    endcase

    // Nothing may reach the memory or be acknowledged while reset is held,
    // so an abandoned clear never writes its next address.
    if (rst) begin
      disp_ack = 1'b0;
      host_ack = 1'b0;
      mem_en   = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
    end

    disp_rd_acc = disp_ack;
    host_rd_acc = host_ack && !host_we;
  end

  // Per-owner tag pipelines match the BRAM read latency; they keep shifting
  // during CLEAR so reads issued just before a clear still return.
  assign disp_pipe_next[0] = disp_rd_acc;
  assign host_pipe_next[0] = host_rd_acc;

  generate
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_pipe
      assign disp_pipe_next[gi] = disp_pipe_reg[gi-1];
      assign host_pipe_next[gi] = host_pipe_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= '0;
      clr_cnt_reg   <= '0;
      disp_pipe_reg <= '0;
      host_pipe_reg <= '0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      clr_cnt_reg   <= clr_cnt_next;
      disp_pipe_reg <= disp_pipe_next;
      host_pipe_reg <= host_pipe_next;
    end
  end

  assign disp_rvalid = disp_pipe_reg[RD_LAT-1];
  assign host_rvalid = host_pipe_reg[RD_LAT-1];
  assign disp_rdata  = mem_dout;
  assign host_rdata  = mem_dout;
  assign clr_busy    = (state_reg == CLEAR);

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb_vga_mem_arbiter
//   Directed bench for vga_mem_arbiter with a behavioural 1024x16
//   write-first BRAM (1-cycle read latency) attached to the mem_* port.
module tb_vga_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_ack;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          clr_start;
  logic          clr_busy;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  always #5 clk = ~clk;

  vga_mem_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(1), .MAX_WAIT(8), .CLR_VAL(16'h0000)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Behavioural BRAM, write-first.
  logic [DW-1:0] bram [0:(1<<AW)-1];
  logic [DW-1:0] bram_q;

  initial begin
    for (int i = 0; i < (1 << AW); i++) bram[i] = '0;
    bram_q = '0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        bram[mem_addr] <= mem_din;
        bram_q         <= mem_din;
      end else begin
        bram_q <= bram[mem_addr];
      end
    end
  end

  assign mem_dout = bram_q;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle;
    disp_req   = 1'b0;
    host_req   = 1'b0;
    host_we    = 1'b0;
    clr_start  = 1'b0;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit verify);
    host_req   = 1'b1;
    host_we    = 1'b1;
    host_addr  = a;
    host_wdata = d;
    settle;
    if (verify) begin
      chk("wr_host_ack", 32'(host_ack), 32'd1);
      chk("wr_disp_ack", 32'(disp_ack), 32'd0);
      chk("wr_mem_we", 32'(mem_we), 32'd1);
    end
    tick;
    host_req = 1'b0;
    host_we  = 1'b0;
  endtask

  task automatic host_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = a;
    settle;
    chk({tag, "_ack"}, 32'(host_ack), 32'd1);
    tick;
    host_req = 1'b0;
    chk({tag, "_rvalid"}, 32'(host_rvalid), 32'd1);
    chk({tag, "_rdata"}, 32'(host_rdata), 32'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs;
    int n;
    logic [AW-1:0] ra [5];

    rst        = 1'b1;
    disp_addr  = '0;
    host_addr  = '0;
    host_wdata = '0;
    idle();
    tick;
    disp_req = 1'b1;
    settle;
    chk("rst_disp_ack", 32'(disp_ack), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    disp_req = 1'b0;
    tick;
    rst = 1'b0;
    settle;
    chk("rst_clr_busy", 32'(clr_busy), 32'd0);
    chk("rst_disp_rvalid", 32'(disp_rvalid), 32'd0);
    chk("rst_host_rvalid", 32'(host_rvalid), 32'd0);

    // 1: host write then read back, display idle
    host_write(10'h005, 16'hBEEF, 1'b1);
    chk("t1_wr_no_rvalid", 32'(host_rvalid), 32'd0);
    host_read("t1_rd", 10'h005, 16'hBEEF);
    chk("t1_disp_rvalid", 32'(disp_rvalid), 32'd0);
    $display("t1 host write/read 0x005 done");

    // 2: continuous display traffic starves host for exactly 8 cycles
    host_write(10'h010, 16'h1234, 1'b0);
    disp_req  = 1'b1;
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 10'h010;
    errs = 0;
    for (int i = 0; i < 8; i++) begin
      disp_addr = 10'h100 + 10'(i);
      settle;
      if (host_ack || !disp_ack) errs++;
      tick;
    end
    chk("t2_starve_cycles", 32'(errs), 32'd0);
    disp_addr = 10'h108;
    settle;
    chk("t2_host_win", 32'(host_ack), 32'd1);
    chk("t2_disp_blocked", 32'(disp_ack), 32'd0);
    tick;
    host_req = 1'b0;
    settle;
    chk("t2_host_rvalid", 32'(host_rvalid), 32'd1);
    chk("t2_host_rdata", 32'(host_rdata), 32'h1234);
    chk("t2_disp_rvalid", 32'(disp_rvalid), 32'd0);
    chk("t2_disp_resume", 32'(disp_ack), 32'd1);
    tick;
    disp_req = 1'b0;
    $display("t2 starvation override done");

    // 3: simultaneous requests with no wait history
    disp_req  = 1'b1;
    disp_addr = 10'h020;
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 10'h005;
    settle;
    chk("t3_disp_first", 32'(disp_ack), 32'd1);
    chk("t3_host_held", 32'(host_ack), 32'd0);
    tick;
    disp_req = 1'b0;
    settle;
    chk("t3_host_next", 32'(host_ack), 32'd1);
    tick;
    host_req = 1'b0;
    chk("t3_host_rvalid", 32'(host_rvalid), 32'd1);
    chk("t3_host_rdata", 32'(host_rdata), 32'hBEEF);
    chk("t3_disp_rvalid", 32'(disp_rvalid), 32'd0);
    $display("t3 priority then handoff done");

    // 4: fill memory, clear it, check length and contents
    for (int a = 0; a < 1024; a++) host_write(10'(a), 16'(a), 1'b0);
    clr_start = 1'b1;
    tick;
    clr_start = 1'b0;
    disp_req  = 1'b1;
    disp_addr = 10'h033;
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 10'h003;
    n = 0;
    errs = 0;
    while (clr_busy && n < 2000) begin
      if (disp_ack || host_ack || !mem_en || !mem_we ||
          mem_addr !== 10'(n) || mem_din !== 16'h0000) errs++;
      n++;
      tick;
    end
    idle();
    chk("t4_clr_len", 32'(n), 32'd1024);
    chk("t4_clr_cycle_errs", 32'(errs), 32'd0);
    ra[0] = 10'h000; ra[1] = 10'h005; ra[2] = 10'h155; ra[3] = 10'h2AA; ra[4] = 10'h3FF;
    for (int i = 0; i < 5; i++) host_read("t4_rd", ra[i], 16'h0000);
    $display("t4 clear sequence done");

    // 5: reset in the middle of a clear, and with a request pending
    host_write(10'h1FF, 16'h7777, 1'b0);
    host_write(10'h200, 16'hAAAA, 1'b0);
    host_write(10'h3FF, 16'h5555, 1'b0);
    clr_start = 1'b1;
    tick;
    clr_start = 1'b0;
    repeat (512) tick;
    chk("t5_mid_addr", 32'(mem_addr), 32'h200);
    chk("t5_mid_busy", 32'(clr_busy), 32'd1);
    rst = 1'b1;
    settle;
    chk("t5_rst_mem_en", 32'(mem_en), 32'd0);
    tick;
    rst = 1'b0;
    settle;
    chk("t5_busy_drop", 32'(clr_busy), 32'd0);
    chk("t5_disp_rvalid", 32'(disp_rvalid), 32'd0);
    chk("t5_host_rvalid", 32'(host_rvalid), 32'd0);
    host_req  = 1'b1;
    host_addr = 10'h200;
    disp_req  = 1'b1;
    disp_addr = 10'h040;
    rst       = 1'b1;
    settle;
    chk("t5_rst_no_ack", 32'(host_ack | disp_ack), 32'd0);
    tick;
    rst = 1'b0;
    idle();
    chk("t5_drop_host_rv", 32'(host_rvalid), 32'd0);
    chk("t5_drop_disp_rv", 32'(disp_rvalid), 32'd0);
    host_read("t5_keep200", 10'h200, 16'hAAAA);
    host_read("t5_keep3ff", 10'h3FF, 16'h5555);
    host_read("t5_clr1ff", 10'h1FF, 16'h0000);
    $display("t5 reset mid-clear done");

    // 6: alternate display/host reads every cycle
    for (int i = 0; i < 8; i++) host_write(10'h040 + 10'(i), 16'hC000 + 16'(i), 1'b0);
    for (int i = 0; i < 8; i++) begin
      if ((i % 2) == 0) begin
        disp_req  = 1'b1;
        disp_addr = 10'h040 + 10'(i);
        host_req  = 1'b0;
      end else begin
        disp_req  = 1'b0;
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 10'h040 + 10'(i);
      end
      settle;
      if ((i % 2) == 0) chk("t6_disp_ack", 32'(disp_ack), 32'd1);
      else              chk("t6_host_ack", 32'(host_ack), 32'd1);
      tick;
      if ((i % 2) == 0) begin
        chk("t6_disp_rvalid", 32'(disp_rvalid), 32'd1);
        chk("t6_host_quiet", 32'(host_rvalid), 32'd0);
        chk("t6_disp_rdata", 32'(disp_rdata), 32'(16'hC000 + 16'(i)));
      end else begin
        chk("t6_host_rvalid", 32'(host_rvalid), 32'd1);
        chk("t6_disp_quiet", 32'(disp_rvalid), 32'd0);
        chk("t6_host_rdata", 32'(host_rdata), 32'(16'hC000 + 16'(i)));
      end
      $display("t6 read %0d addr=%0h", i, 10'h040 + 10'(i));
    end
    idle();
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
